nonrestoring_divider_core: RTL

Sequential unsigned non-restoring divider that computes a quotient and a raw partial remainder. It sits directly upstream of the remainder-select multiplexer stage. At the end of the iterations it presents two remainder candidates (REG1 = raw, REG2 = raw + divisor) and the signed raw remainder R, then pulses Enable so the multiplexer can latch the correct final remainder. It waits for the multiplexer's FLAG before reporting done.

---
 rtl/nrdiv_pkg.sv | 16 +
 rtl/nonrestoring_divider_core_if.sv | 34 +++
 rtl/nrdiv_addsub.sv | 17 +
 rtl/nonrestoring_divider_core.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/nrdiv_pkg.sv
// Shared types and sizing for the non-restoring divider slice.
// Holds the default width, FSM states and iteration counter width.
package nrdiv_pkg;

  localparam int NRDIV_WIDTH = 16;
  localparam int NRDIV_CNT_W = $clog2(NRDIV_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    CORR,
    WAIT_ACK
  } nrdiv_state_e;

endpackage

// File: rtl/nonrestoring_divider_core_if.sv
// Request/result bundle between the divider and its neighbours.
// master = requester/remainder mux side, slave = divider core.
interface nonrestoring_divider_core_if
  import nrdiv_pkg::*;
#(
  parameter int WIDTH = NRDIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             FLAG;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] REG1;
  logic [WIDTH-1:0] REG2;
  logic [WIDTH-1:0] R;
  logic             Enable;
  logic             div0;

  modport master (
    output start, dividend, divisor, FLAG,
    input  busy, done, quotient,
    input  REG1, REG2, R, Enable, div0
  );

  modport slave (
    input  start, dividend, divisor, FLAG,
    output busy, done, quotient,
    output REG1, REG2, R, Enable, div0
  );

endinterface

// File: rtl/nrdiv_addsub.sv
// Partial-remainder adder: y = a - b when sub_i, else a + b.
// Shared by the iteration step and the rem + D candidate.
module nrdiv_addsub #(
  parameter int W = 18
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] y_o
);

  // one adder, operand inverted for subtract
  always_comb begin
    y_o = sub_i ? (a_i - b_i) : (a_i + b_i);
  end

endmodule

// File: rtl/nonrestoring_divider_core.sv
// Unsigned non-restoring divider; final remainder picked downstream.
// Optional NRDIV_DIV0_DETECT_EN: short-cut and flag divide by zero.
module nonrestoring_divider_core
  import nrdiv_pkg::*;
#(
  parameter int WIDTH = NRDIV_WIDTH
) (
  input logic                        clk,
  input logic                        rst,
  nonrestoring_divider_core_if.slave bus
);

  localparam int RW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);

  nrdiv_state_e state_q, state_d;

  logic [RW-1:0]    rem_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;

  logic [WIDTH-1:0] quo_q, reg1_q, reg2_q, r_q;
  logic [WIDTH-1:0] quo_c, reg1_c, reg2_c, r_c;
  logic             div0_c;

  logic [RW-1:0] rem_sh;
  logic [RW-1:0] as_a;
  logic [RW-1:0] as_y;
  logic          as_sub;
  logic          in_iter;
  logic          last_it;

  assign in_iter = (state_q == ITER);
  assign last_it = (cnt_q == CW'(WIDTH - 1));
  assign rem_sh  = {rem_q[RW-2:0], q_q[WIDTH-1]};
  assign as_a    = in_iter ? rem_sh : rem_q;
  assign as_sub  = in_iter & ~rem_q[RW-1];

  nrdiv_addsub #(
    .W (RW)
  ) u_addsub (
    .a_i   (as_a),
    .b_i   ({2'b00, d_q}),
    .sub_i (as_sub),
    .y_o   (as_y)
  );

`ifdef NRDIV_DIV0_DETECT_EN
  logic dz_q;
  logic div0_q;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (bus.start) state_d = LOAD;
`ifdef NRDIV_DIV0_DETECT_EN
      LOAD:     state_d = dz_q ? CORR : ITER;
`else
      LOAD:     state_d = ITER;
`endif
      ITER:     if (last_it) state_d = CORR;
      CORR:     state_d = WAIT_ACK;
      WAIT_ACK: if (bus.FLAG) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // result candidates presented while in CORR
  always_comb begin
    quo_c  = q_q;
    reg1_c = rem_q[WIDTH-1:0];
    reg2_c = as_y[WIDTH-1:0];
    r_c    = {rem_q[RW-1], rem_q[WIDTH-2:0]};
    div0_c = 1'b0;
`ifdef NRDIV_DIV0_DETECT_EN
    if (dz_q) begin
      quo_c  = '1;
      reg1_c = q_q;
      reg2_c = q_q;
      r_c    = '0;
      div0_c = 1'b1;
    end
`endif
  end

  // operand capture, iteration and result hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      q_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      quo_q  <= '0;
      reg1_q <= '0;
      reg2_q <= '0;
      r_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == WAIT_ACK) && bus.FLAG;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            q_q <= bus.dividend;
            d_q <= bus.divisor;
          end
        end
        LOAD: begin
          rem_q <= '0;
          cnt_q <= '0;
        end
        ITER: begin
          rem_q <= as_y;
          q_q   <= {q_q[WIDTH-2:0], ~as_y[RW-1]};
          cnt_q <= cnt_q + 1'b1;
        end
        CORR: begin
          quo_q  <= quo_c;
          reg1_q <= reg1_c;
          reg2_q <= reg2_c;
          r_q    <= r_c;
        end
        default: ;
      endcase
    end
  end

`ifdef NRDIV_DIV0_DETECT_EN
  // zero-divisor tag and sticky flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dz_q   <= 1'b0;
      div0_q <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      dz_q   <= (bus.divisor == '0);
      div0_q <= 1'b0;
    end else if (state_q == CORR) begin
      div0_q <= div0_c;
    end
  end

  assign bus.div0 = (state_q == CORR) ? div0_c : div0_q;
`else
  assign bus.div0 = div0_c;
`endif

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.Enable   = (state_q == CORR);
  assign bus.quotient = (state_q == CORR) ? quo_c  : quo_q;
  assign bus.REG1     = (state_q == CORR) ? reg1_c : reg1_q;
  assign bus.REG2     = (state_q == CORR) ? reg2_c : reg2_q;
  assign bus.R        = (state_q == CORR) ? r_c    : r_q;

endmodule
